brush_painter: RTL

Parametrised successor to the fixed 64x64 cursor/paint path in the paint top level. It accepts decoded mouse packets through a valid/ready handshake, keeps a clamped or wrapping cursor position, and cycles the brush size on the middle button. On left (paint) or right (erase) it draws a square brush into the framebuffer through a back-pressured write port. It sits between mouse_rx and the framebuffer memory write side.

---
 rtl/brush_painter_if.sv | 41 ++++
 rtl/brush_painter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/brush_painter_if.sv
// -----------------------------------------------------------------------------
// brush_painter_if
// Bundles the two handshakes of the brush painter:
//   * packet side : pkt_valid/pkt_ready, delta_x/delta_y, btn_left/right/middle,
//                   wrap_mode (decoded mouse packets coming from mouse_rx)
//   * write side  : wr_en/wr_ready, wr_addr ({y,x}), wr_data (framebuffer port)
// Modports:
//   master : the environment (mouse source + framebuffer)
//   slave  : the brush_painter block itself
// -----------------------------------------------------------------------------
interface brush_painter_if #(
    parameter int X_W     = 6,
    parameter int Y_W     = 6,
    parameter int DELTA_W = 8,
    parameter int COLOR_W = 12
);
    logic               pkt_valid;
    logic               pkt_ready;
    logic [DELTA_W-1:0] delta_x;
    logic [DELTA_W-1:0] delta_y;
    logic               btn_left;
    logic               btn_right;
    logic               btn_middle;
    logic               wrap_mode;
    logic               wr_en;
    logic [X_W+Y_W-1:0] wr_addr;
    logic [COLOR_W-1:0] wr_data;
    logic               wr_ready;

    modport master (
        output pkt_valid, delta_x, delta_y, btn_left, btn_right, btn_middle,
               wrap_mode, wr_ready,
        input  pkt_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  pkt_valid, delta_x, delta_y, btn_left, btn_right, btn_middle,
               wrap_mode, wr_ready,
        output pkt_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/brush_painter.sv
// -----------------------------------------------------------------------------
// brush_painter
// Takes decoded mouse packets, keeps a clamped or wrapping cursor, cycles the
// brush edge on middle-button presses and draws a square brush (paint on left,
// erase on right) into the framebuffer through a back-pressured write port.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus (slave)    : packet handshake in, framebuffer write handshake out
//   o_pos_x/o_pos_y: current cursor
//   o_brush_sz     : current brush edge (1..BRUSH_MAX)
//   o_busy         : high whenever the block is not idle
// Optional build macro: MIRROR_EN -- every in-range brush pixel is followed by
// a second write at x' = X_MAX - x on the same row (skipped when x' == x).
// -----------------------------------------------------------------------------
module brush_painter #(
    parameter int                 X_W         = 6,
    parameter int                 Y_W         = 6,
    parameter int                 X_MAX       = 63,
    parameter int                 Y_MAX       = 63,
    parameter int                 DELTA_W     = 8,
    parameter int                 COLOR_W     = 12,
    parameter logic [COLOR_W-1:0] PAINT_COLOR = 12'hF00,
    parameter logic [COLOR_W-1:0] ERASE_COLOR = 12'h000,
    parameter int                 BRUSH_MAX   = 4
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    brush_painter_if.slave bus,
    output logic [X_W-1:0] o_pos_x,
    output logic [Y_W-1:0] o_pos_y,
    output logic [2:0]     o_brush_sz,
    output logic           o_busy
);
    // Signed working width: wide enough for pos +/- the largest delta.
    localparam int XY_W = (X_W > Y_W) ? X_W : Y_W;
    localparam int AW   = ((XY_W > DELTA_W) ? XY_W : DELTA_W) + 2;
    localparam int TXW  = X_W + 4;
    localparam int TYW  = Y_W + 4;
    localparam logic signed [AW-1:0] X_LIM = AW'(X_MAX);
    localparam logic signed [AW-1:0] Y_LIM = AW'(Y_MAX);
    localparam logic signed [AW-1:0] X_MOD = AW'(X_MAX + 1);
    localparam logic signed [AW-1:0] Y_MOD = AW'(Y_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_PAINT  = 2'd2
    } state_t;

    // Clamp to [0,lim] or fold into [0,lim] with a true modulus (the delta can
    // span several multiples of the range, so one correction is not enough).
    function automatic logic signed [AW-1:0] fold_f(
        input logic signed [AW-1:0] v,
        input logic signed [AW-1:0] lim,
        input logic signed [AW-1:0] modv,
        input logic                 wrap
    );
        logic signed [AW-1:0] m;
        m = v % modv;
        if (wrap) begin
            if (m[AW-1]) fold_f = m + modv;
            else         fold_f = m;
        end else begin
            if (v[AW-1])       fold_f = '0;
            else if (v > lim)  fold_f = lim;
            else               fold_f = v;
        end
    endfunction

    state_t               r_state;
    state_t               w_state_nxt;
    logic [DELTA_W-1:0]   r_dx;
    logic [DELTA_W-1:0]   r_dy;
    logic                 r_btn_l;
    logic                 r_btn_r;
    logic                 r_btn_m;
    logic                 r_prev_mid;
    logic [X_W-1:0]       r_pos_x;
    logic [Y_W-1:0]       r_pos_y;
    logic [3:0]           r_brush;
    logic [2:0]           r_cnt_x;
    logic [2:0]           r_cnt_y;
    logic                 r_wr_en;
    logic [X_W+Y_W-1:0]   r_wr_addr;
    logic [COLOR_W-1:0]   r_wr_data;

    logic signed [AW-1:0] w_sum_x;
    logic signed [AW-1:0] w_sum_y;
    logic [X_W-1:0]       w_nx;
    logic [Y_W-1:0]       w_ny;
    logic [3:0]           w_brush_nxt;
    logic [3:0]           w_sz_m1;
    logic                 w_end_x;
    logic                 w_last;
    logic [2:0]           w_ncx;
    logic [2:0]           w_ncy;
    logic [TXW-1:0]       w_ntx;
    logic [TYW-1:0]       w_nty;
    logic                 w_nin;
    logic                 w_step;
    logic                 w_done;

    // Cursor arithmetic: y grows downward on screen, so a positive dy moves up.
    assign w_sum_x = $signed({{(AW-X_W){1'b0}}, r_pos_x}) + $signed({{(AW-DELTA_W){r_dx[DELTA_W-1]}}, r_dx});
    assign w_sum_y = $signed({{(AW-Y_W){1'b0}}, r_pos_y}) - $signed({{(AW-DELTA_W){r_dy[DELTA_W-1]}}, r_dy});
    assign w_nx    = X_W'(fold_f(w_sum_x, X_LIM, X_MOD, bus.wrap_mode));
    assign w_ny    = Y_W'(fold_f(w_sum_y, Y_LIM, Y_MOD, bus.wrap_mode));

    // Brush size steps only on a middle-button rising edge between packets.
    always_comb begin
        w_brush_nxt = r_brush;
        if (r_btn_m && !r_prev_mid) begin
            if (r_brush == 4'(BRUSH_MAX)) w_brush_nxt = 4'd1;
            else                          w_brush_nxt = r_brush + 4'd1;
        end else begin
            w_brush_nxt = r_brush;
        end
    end

    // Brush scan bookkeeping: the current slot completes when it was a skip
    // (wr_en low) or when the write is accepted.
    assign w_sz_m1 = r_brush - 4'd1;
    assign w_end_x = ({1'b0, r_cnt_x} == w_sz_m1);
    assign w_last  = w_end_x && ({1'b0, r_cnt_y} == w_sz_m1);
    assign w_step  = !r_wr_en || bus.wr_ready;

    // Next brush target in raster order (dx inner, dy outer).
    always_comb begin
        w_ncx = r_cnt_x;
        w_ncy = r_cnt_y;
        if (w_end_x) begin
            w_ncx = 3'd0;
            w_ncy = r_cnt_y + 3'd1;
        end else begin
            w_ncx = r_cnt_x + 3'd1;
            w_ncy = r_cnt_y;
        end
    end

    assign w_ntx = TXW'(r_pos_x) + TXW'(w_ncx);
    assign w_nty = TYW'(r_pos_y) + TYW'(w_ncy);
    assign w_nin = (w_ntx <= TXW'(X_MAX)) && (w_nty <= TYW'(Y_MAX));

`ifdef MIRROR_EN
    logic           r_mir;
    logic [X_W-1:0] w_mir_x;
    logic           w_need_mir;

    // A primary write whose mirror column differs must be followed by its twin.
    assign w_mir_x    = X_W'(X_MAX) - r_wr_addr[X_W-1:0];
    assign w_need_mir = r_wr_en && !r_mir && (w_mir_x != r_wr_addr[X_W-1:0]);
    assign w_done     = w_step && !w_need_mir && w_last;

    // Mirror phase flag: set while the twin write is outstanding.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mir <= 1'b0;
        end else if (r_state != ST_PAINT) begin
            r_mir <= 1'b0;
        end else if (w_step) begin
            r_mir <= w_need_mir;
        end
    end
`else
    assign w_done = w_step && w_last;
`endif

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.pkt_valid) w_state_nxt = ST_UPDATE;
                else               w_state_nxt = ST_IDLE;
            end
            ST_UPDATE: begin
                if (r_btn_l || r_btn_r) w_state_nxt = ST_PAINT;
                else                    w_state_nxt = ST_IDLE;
            end
            ST_PAINT: begin
                if (w_done) w_state_nxt = ST_IDLE;
                else        w_state_nxt = ST_PAINT;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: packet latch, cursor/brush update and the brush write scan.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dx       <= '0;
            r_dy       <= '0;
            r_btn_l    <= 1'b0;
            r_btn_r    <= 1'b0;
            r_btn_m    <= 1'b0;
            r_prev_mid <= 1'b0;
            r_pos_x    <= X_W'(X_MAX / 2);
            r_pos_y    <= Y_W'(Y_MAX / 2);
            r_brush    <= 4'd1;
            r_cnt_x    <= 3'd0;
            r_cnt_y    <= 3'd0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.pkt_valid) begin
                        r_dx    <= bus.delta_x;
                        r_dy    <= bus.delta_y;
                        r_btn_l <= bus.btn_left;
                        r_btn_r <= bus.btn_right;
                        r_btn_m <= bus.btn_middle;
                    end
                end
                ST_UPDATE: begin
                    r_pos_x    <= w_nx;
                    r_pos_y    <= w_ny;
                    r_brush    <= w_brush_nxt;
                    r_prev_mid <= r_btn_m;
                    r_cnt_x    <= 3'd0;
                    r_cnt_y    <= 3'd0;
                    // The brush origin is the new cursor, which is always in range.
                    if (r_btn_l || r_btn_r) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= {w_ny, w_nx};
                        r_wr_data <= r_btn_l ? PAINT_COLOR : ERASE_COLOR;
                    end
                end
                ST_PAINT: begin
                    if (w_step) begin
`ifdef MIRROR_EN
                        if (w_need_mir) begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= {r_wr_addr[X_W+Y_W-1:X_W], w_mir_x};
                        end else
`endif
                        if (w_last) begin
                            r_wr_en <= 1'b0;
                        end else begin
                            r_cnt_x   <= w_ncx;
                            r_cnt_y   <= w_ncy;
                            r_wr_en   <= w_nin;
                            r_wr_addr <= {w_nty[Y_W-1:0], w_ntx[X_W-1:0]};
                        end
                    end
                end
                default: begin
                    r_wr_en <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pkt_ready = (r_state == ST_IDLE);
    assign bus.wr_en     = r_wr_en;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = r_wr_data;
    assign o_pos_x       = r_pos_x;
    assign o_pos_y       = r_pos_y;
    assign o_brush_sz    = r_brush[2:0];
    assign o_busy        = (r_state != ST_IDLE);
endmodule
